// File: rtl/fifo_ram_multi.sv
// Multi-lane circular FIFO with random-access read/write ports and whole-queue flush.
// Optional tail rollback (rollback_valid_i/rollback_ptr_i) when FIFO_RAM_MULTI_ROLLBACK_EN is defined.
module fifo_ram_multi #(
   parameter int ENTRY_WIDTH   = 32,
   parameter int N_ENTRIES     = 8,
   parameter int N_ENQ         = 2,
   parameter int N_DEQ         = 2,
   parameter int N_READ_PORTS  = 2,
   parameter int N_WRITE_PORTS = 2,
   localparam int PTR_WIDTH    = $clog2(N_ENTRIES),
   localparam int CTR_WIDTH    = PTR_WIDTH + 1
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     flush_i,
   output logic [N_ENQ-1:0]                         enq_ready_o,
   input  logic [N_ENQ-1:0]                         enq_valid_i,
   input  logic [N_ENQ-1:0][ENTRY_WIDTH-1:0]        enq_data_i,
   input  logic [N_DEQ-1:0]                         deq_ready_i,
   output logic [N_DEQ-1:0]                         deq_valid_o,
   output logic [N_DEQ-1:0][ENTRY_WIDTH-1:0]        deq_data_o,
   input  logic [N_READ_PORTS-1:0][PTR_WIDTH-1:0]   rd_addr_i,
   output logic [N_READ_PORTS-1:0][ENTRY_WIDTH-1:0] rd_data_o,
   input  logic [N_WRITE_PORTS-1:0]                 wr_en_i,
   input  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]  wr_addr_i,
   input  logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data_i,
`ifdef FIFO_RAM_MULTI_ROLLBACK_EN
   input  logic                                     rollback_valid_i,
   input  logic [CTR_WIDTH-1:0]                     rollback_ptr_i,
`endif
   output logic [CTR_WIDTH-1:0]                     enq_ptr_o,
   output logic [CTR_WIDTH-1:0]                     deq_ptr_o,
   output logic [CTR_WIDTH-1:0]                     count_o,
   output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]    entry_douts_o
);

   logic [CTR_WIDTH-1:0]   enq_ptr_q, enq_ptr_d;
   logic [CTR_WIDTH-1:0]   deq_ptr_q, deq_ptr_d;
   logic [ENTRY_WIDTH-1:0] entries_q [N_ENTRIES];
   logic [ENTRY_WIDTH-1:0] entries_d [N_ENTRIES];

   logic [CTR_WIDTH-1:0]   count;
   logic [CTR_WIDTH-1:0]   free;
   logic [N_ENQ-1:0]       enq_fire;
   logic [CTR_WIDTH-1:0]   n_enq;
   logic [CTR_WIDTH-1:0]   n_deq;
   logic                   rb_valid;
   logic [CTR_WIDTH-1:0]   rb_ptr;

`ifdef FIFO_RAM_MULTI_ROLLBACK_EN
   assign rb_valid = rollback_valid_i;
   assign rb_ptr   = rollback_ptr_i;
`else
   assign rb_valid = 1'b0;
   assign rb_ptr   = '0;
`endif

   // The extra wrap bit makes the modular difference an exact occupancy.
   assign count = enq_ptr_q - deq_ptr_q;
   assign free  = CTR_WIDTH'(N_ENTRIES) - count;

   always_comb begin
      logic chain;
      chain = 1'b1;
      n_enq = '0;
      for (int i = 0; i < N_ENQ; i++) begin
         enq_ready_o[i] = (int'(free) > i);
         chain          = chain & enq_valid_i[i] & enq_ready_o[i];
         enq_fire[i]    = chain;
         n_enq          = n_enq + CTR_WIDTH'(chain);
      end
   end

   always_comb begin
      logic chain;
      chain = 1'b1;
      n_deq = '0;
      for (int i = 0; i < N_DEQ; i++) begin
         deq_valid_o[i] = (int'(count) > i);
         chain          = chain & deq_ready_i[i] & deq_valid_o[i];
         n_deq          = n_deq + CTR_WIDTH'(chain);
      end
   end

   // Later assignments win: low write port, then high write port, then enqueue lanes.
   always_comb begin
      for (int k = 0; k < N_ENTRIES; k++) begin
         entries_d[k] = entries_q[k];
      end
      for (int p = 0; p < N_WRITE_PORTS; p++) begin
         if (wr_en_i[p]) begin
            entries_d[wr_addr_i[p]] = wr_data_i[p];
         end
      end
      if (!flush_i && !rb_valid) begin
         for (int i = 0; i < N_ENQ; i++) begin
            if (enq_fire[i]) begin
               entries_d[PTR_WIDTH'(enq_ptr_q + CTR_WIDTH'(i))] = enq_data_i[i];
            end
         end
      end
   end

   always_comb begin
      enq_ptr_d = enq_ptr_q + n_enq;
      deq_ptr_d = deq_ptr_q + n_deq;
      if (flush_i) begin
         enq_ptr_d = '0;
         deq_ptr_d = '0;
      end else if (rb_valid) begin
         enq_ptr_d = rb_ptr;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         enq_ptr_q <= '0;
         deq_ptr_q <= '0;
         for (int k = 0; k < N_ENTRIES; k++) begin
            entries_q[k] <= '0;
         end
      end else begin
         enq_ptr_q <= enq_ptr_d;
         deq_ptr_q <= deq_ptr_d;
         for (int k = 0; k < N_ENTRIES; k++) begin
            entries_q[k] <= entries_d[k];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_DEQ; i++) begin
         deq_data_o[i] = entries_q[PTR_WIDTH'(deq_ptr_q + CTR_WIDTH'(i))];
      end
   end

   always_comb begin
      for (int i = 0; i < N_READ_PORTS; i++) begin
         rd_data_o[i] = entries_q[rd_addr_i[i]];
      end
   end

   always_comb begin
      for (int k = 0; k < N_ENTRIES; k++) begin
         entry_douts_o[k] = entries_q[k];
      end
   end

   assign enq_ptr_o = enq_ptr_q;
   assign deq_ptr_o = deq_ptr_q;
   assign count_o   = count;

endmodule

// File: tb/tb_fifo_ram_multi.sv
// Self-checking bench for fifo_ram_multi: directed scenarios plus random traffic against a queue model.
// Rollback scenario runs when FIFO_RAM_MULTI_ROLLBACK_EN is defined.
module tb_fifo_ram_multi;
   localparam int W  = 32;
   localparam int N  = 8;
   localparam int NE = 2;
   localparam int ND = 2;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int PW = 3;
   localparam int CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst, flush;
   logic [NE-1:0]          enq_valid;
   logic [NE-1:0][W-1:0]   enq_data;
   logic [ND-1:0]          deq_ready;
   logic [NR-1:0][PW-1:0]  rd_addr;
   logic [NW-1:0]          wr_en;
   logic [NW-1:0][PW-1:0]  wr_addr;
   logic [NW-1:0][W-1:0]   wr_data;
   logic                   rb_valid;
   logic [CW-1:0]          rb_ptr;
   logic [NE-1:0]          enq_ready;
   logic [ND-1:0]          deq_valid;
   logic [ND-1:0][W-1:0]   deq_data;
   logic [NR-1:0][W-1:0]   rd_data;
   logic [CW-1:0]          enq_ptr, deq_ptr, count;
   logic [N-1:0][W-1:0]    entry_douts;

   fifo_ram_multi #(.ENTRY_WIDTH(W), .N_ENTRIES(N), .N_ENQ(NE), .N_DEQ(ND),
                    .N_READ_PORTS(NR), .N_WRITE_PORTS(NW)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .enq_ready_o(enq_ready), .enq_valid_i(enq_valid), .enq_data_i(enq_data),
      .deq_ready_i(deq_ready), .deq_valid_o(deq_valid), .deq_data_o(deq_data),
      .rd_addr_i(rd_addr), .rd_data_o(rd_data),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
`ifdef FIFO_RAM_MULTI_ROLLBACK_EN
      .rollback_valid_i(rb_valid), .rollback_ptr_i(rb_ptr),
`endif
      .enq_ptr_o(enq_ptr), .deq_ptr_o(deq_ptr), .count_o(count),
      .entry_douts_o(entry_douts)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: slot storage plus unbounded-style integer pointers taken mod 2N.
   logic [W-1:0] m_mem [N];
   int           m_ep, m_dp;

   function automatic int m_cnt();
      return ((m_ep - m_dp) % (2 * N) + 2 * N) % (2 * N);
   endfunction

   task automatic m_edge();
      int cnt, fr, ne, nd;
      if (rst) begin
         m_ep = 0;
         m_dp = 0;
         for (int k = 0; k < N; k++) m_mem[k] = '0;
      end else begin
         cnt = m_cnt();
         fr  = N - cnt;
         ne  = 0;
         while (ne < NE && enq_valid[ne] && ne < fr) ne++;
         nd  = 0;
         while (nd < ND && deq_ready[nd] && nd < cnt) nd++;
         for (int p = 0; p < NW; p++) if (wr_en[p]) m_mem[wr_addr[p]] = wr_data[p];
         if (flush) begin
            m_ep = 0;
            m_dp = 0;
         end else begin
            if (rb_valid) m_ep = int'(rb_ptr);
            else begin
               for (int i = 0; i < ne; i++) m_mem[(m_ep + i) % N] = enq_data[i];
               m_ep = (m_ep + ne) % (2 * N);
            end
            m_dp = (m_dp + nd) % (2 * N);
         end
      end
   endtask

   task automatic step();
      m_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; flush = 1'b0; enq_valid = '0; enq_data = '0; deq_ready = '0;
      rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; rb_valid = 1'b0; rb_ptr = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic push2(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         enq_valid = 2'b11;
         enq_data[0] = $urandom();
         enq_data[1] = $urandom();
         step();
      end
      idle();
   endtask

   task automatic pop2(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         deq_ready = 2'b11;
         step();
      end
      idle();
   endtask

   task automatic test_reset();
      bit all_zero;
      enq_valid = 2'b11; enq_data[0] = 32'h1111_1111; wr_en = 2'b11;
      wr_addr[0] = 3'd2; wr_data[0] = 32'h2222_2222;
      step();
      do_reset();
      #1;
      n_checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
      n_checks++; if (enq_ptr !== 4'd0 || deq_ptr !== 4'd0) $display("FAIL reset_ptrs: got %0d/%0d want 0/0", enq_ptr, deq_ptr); else n_pass++;
      n_checks++; if (deq_valid !== 2'b00) $display("FAIL reset_deq_valid: got %b want 00", deq_valid); else n_pass++;
      n_checks++; if (enq_ready !== 2'b11) $display("FAIL reset_enq_ready: got %b want 11", enq_ready); else n_pass++;
      all_zero = 1'b1;
      for (int k = 0; k < N; k++) if (entry_douts[k] !== '0) all_zero = 1'b0;
      n_checks++; if (!all_zero) $display("FAIL reset_entries: got %h want all zero", entry_douts); else n_pass++;
   endtask

   task automatic test_basic_enq();
      logic [W-1:0] a, b;
      do_reset();
      a = 32'hA0A0_0001; b = 32'hB0B0_0002;
      enq_valid = 2'b11; enq_data[0] = a; enq_data[1] = b;
      step();
      idle();
      #1;
      n_checks++; if (count !== 4'd2) $display("FAIL basic_count: got %0d want 2", count); else n_pass++;
      n_checks++; if (deq_valid !== 2'b11) $display("FAIL basic_deq_valid: got %b want 11", deq_valid); else n_pass++;
      n_checks++; if (deq_data !== {b, a}) $display("FAIL basic_deq_data: got %h want %h", deq_data, {b, a}); else n_pass++;
      n_checks++; if (enq_ptr !== 4'd2) $display("FAIL basic_enq_ptr: got %0d want 2", enq_ptr); else n_pass++;
   endtask

   task automatic test_fill();
      do_reset();
      push2(4);
      #1;
      n_checks++; if (count !== 4'd8) $display("FAIL fill_count: got %0d want 8", count); else n_pass++;
      n_checks++; if (enq_ready !== 2'b00) $display("FAIL fill_enq_ready: got %b want 00", enq_ready); else n_pass++;
      n_checks++; if (enq_ptr !== 4'd8) $display("FAIL fill_enq_ptr: got %0d want 8", enq_ptr); else n_pass++;
      n_checks++; if (deq_valid !== 2'b11) $display("FAIL fill_deq_valid: got %b want 11", deq_valid); else n_pass++;
      push2(1);
      #1;
      n_checks++; if (count !== 4'd8 || enq_ptr !== 4'd8) $display("FAIL full_enq_ignored: got count %0d ptr %0d want 8/8", count, enq_ptr); else n_pass++;
      n_checks++; if (deq_data[0] !== m_mem[0]) $display("FAIL full_head: got %h want %h", deq_data[0], m_mem[0]); else n_pass++;
   endtask

   task automatic test_partial();
      do_reset();
      push2(3);
      enq_valid = 2'b01; enq_data[0] = $urandom();
      step();
      idle();
      #1;
      n_checks++; if (count !== 4'd7 || enq_ready !== 2'b01) $display("FAIL part7: got count %0d ready %b want 7/01", count, enq_ready); else n_pass++;
      enq_valid = 2'b11; enq_data[0] = 32'hC0DE_0007; enq_data[1] = 32'hC0DE_0008;
      step();
      idle();
      #1;
      n_checks++; if (count !== 4'd8 || enq_ptr !== 4'd8) $display("FAIL part_one_lane: got count %0d ptr %0d want 8/8", count, enq_ptr); else n_pass++;
      n_checks++; if (entry_douts[7] !== 32'hC0DE_0007) $display("FAIL part_slot7: got %h want c0de0007", entry_douts[7]); else n_pass++;
      deq_ready = 2'b01;
      step();
      idle();
      enq_valid = 2'b11; deq_ready = 2'b11; enq_data[0] = $urandom(); enq_data[1] = $urandom();
      #1;
      n_checks++; if (enq_ready !== 2'b01) $display("FAIL part_no_credit: got %b want 01", enq_ready); else n_pass++;
      step();
      idle();
      #1;
      n_checks++; if (count !== 4'd6) $display("FAIL part_enq_deq: got %0d want 6", count); else n_pass++;
      n_checks++; if (deq_data[0] !== m_mem[m_dp % N]) $display("FAIL part_head: got %h want %h", deq_data[0], m_mem[m_dp % N]); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [W-1:0] d [4];
      do_reset();
      push2(3);
      pop2(3);
      #1;
      n_checks++; if (deq_ptr !== 4'd6 || count !== 4'd0) $display("FAIL wrap_start: got ptr %0d count %0d want 6/0", deq_ptr, count); else n_pass++;
      for (int c = 0; c < 2; c++) begin
         d[2*c] = $urandom(); d[2*c+1] = $urandom();
         enq_valid = 2'b11; enq_data[0] = d[2*c]; enq_data[1] = d[2*c+1];
         step();
      end
      idle();
      #1;
      n_checks++; if ({entry_douts[1], entry_douts[0], entry_douts[7], entry_douts[6]} !== {d[3], d[2], d[1], d[0]})
         $display("FAIL wrap_slots: got %h %h %h %h want %h %h %h %h", entry_douts[6], entry_douts[7], entry_douts[0], entry_douts[1], d[0], d[1], d[2], d[3]);
      else n_pass++;
      for (int c = 0; c < 2; c++) begin
         deq_ready = 2'b11;
         #1;
         n_checks++; if (deq_data !== {d[2*c+1], d[2*c]}) $display("FAIL wrap_order%0d: got %h want %h", c, deq_data, {d[2*c+1], d[2*c]}); else n_pass++;
         step();
      end
      idle();
      #1;
      n_checks++; if (enq_ptr !== 4'd10 || deq_ptr !== 4'd10 || count !== 4'd0) $display("FAIL wrap_end: got %0d/%0d/%0d want 10/10/0", enq_ptr, deq_ptr, count); else n_pass++;
   endtask

   task automatic test_gap();
      do_reset();
      push2(1);
      enq_valid = 2'b10; deq_ready = 2'b10; enq_data[1] = $urandom();
      step();
      idle();
      #1;
      n_checks++; if (count !== 4'd2 || enq_ptr !== 4'd2 || deq_ptr !== 4'd0) $display("FAIL gap: got %0d/%0d/%0d want 2/2/0", count, enq_ptr, deq_ptr); else n_pass++;
      n_checks++; if (entry_douts[2] !== '0) $display("FAIL gap_no_write: got %h want 0", entry_douts[2]); else n_pass++;
   endtask

   task automatic test_flush();
      logic [W-1:0] s0, x;
      do_reset();
      push2(2);
      enq_valid = 2'b01; enq_data[0] = $urandom();
      step();
      idle();
      s0 = m_mem[0];
      x  = 32'hF1F1_0707;
      flush = 1'b1; deq_ready = 2'b11; enq_valid = 2'b11; enq_data[0] = $urandom(); enq_data[1] = $urandom();
      wr_en = 2'b01; wr_addr[0] = 3'd7; wr_data[0] = x;
      #1;
      n_checks++; if (enq_ready !== 2'b11 || deq_valid !== 2'b11) $display("FAIL flush_pre: got ready %b valid %b want 11/11", enq_ready, deq_valid); else n_pass++;
      step();
      idle();
      #1;
      n_checks++; if (count !== 4'd0 || enq_ptr !== 4'd0 || deq_ptr !== 4'd0) $display("FAIL flush_ptrs: got %0d/%0d/%0d want 0/0/0", count, enq_ptr, deq_ptr); else n_pass++;
      n_checks++; if (deq_valid !== 2'b00) $display("FAIL flush_deq_valid: got %b want 00", deq_valid); else n_pass++;
      n_checks++; if (entry_douts[7] !== x) $display("FAIL flush_wr_commit: got %h want %h", entry_douts[7], x); else n_pass++;
      n_checks++; if (entry_douts[0] !== s0 || entry_douts[5] !== '0) $display("FAIL flush_contents: got %h/%h want %h/0", entry_douts[0], entry_douts[5], s0); else n_pass++;
   endtask

   task automatic test_collision();
      logic [W-1:0] old3;
      do_reset();
      enq_valid = 2'b01; enq_data[0] = 32'hE0E0_0000;
      wr_en = 2'b11; wr_addr[0] = 3'd0; wr_addr[1] = 3'd0; wr_data[0] = 32'h0000_00A0; wr_data[1] = 32'h0000_00A1;
      step();
      idle();
      #1;
      n_checks++; if (entry_douts[0] !== 32'hE0E0_0000) $display("FAIL coll_enq_wins: got %h want e0e00000", entry_douts[0]); else n_pass++;
      wr_en = 2'b11; wr_addr[0] = 3'd3; wr_addr[1] = 3'd3; wr_data[0] = 32'h0000_00B0; wr_data[1] = 32'h0000_00B1;
      step();
      idle();
      #1;
      n_checks++; if (entry_douts[3] !== 32'h0000_00B1) $display("FAIL coll_port_prio: got %h want 000000b1", entry_douts[3]); else n_pass++;
      old3 = entry_douts[3];
      rd_addr[0] = 3'd3; rd_addr[1] = 3'd0;
      wr_en = 2'b01; wr_addr[0] = 3'd3; wr_data[0] = 32'h5151_5151;
      #1;
      n_checks++; if (rd_data[0] !== old3 || rd_data[1] !== 32'hE0E0_0000) $display("FAIL rd_pre_edge: got %h/%h want %h/e0e00000", rd_data[0], rd_data[1], old3); else n_pass++;
      step();
      wr_en = '0;
      #1;
      n_checks++; if (rd_data[0] !== 32'h5151_5151) $display("FAIL rd_post_edge: got %h want 51515151", rd_data[0]); else n_pass++;
      idle();
   endtask

`ifdef FIFO_RAM_MULTI_ROLLBACK_EN
   task automatic test_rollback();
      do_reset();
      push2(3);
      pop2(1);
      rb_valid = 1'b1; rb_ptr = 4'd4; enq_valid = 2'b11; enq_data[0] = $urandom(); enq_data[1] = $urandom();
      step();
      idle();
      #1;
      n_checks++; if (count !== 4'd2 || enq_ptr !== 4'd4 || deq_ptr !== 4'd2) $display("FAIL rollback: got %0d/%0d/%0d want 2/4/2", count, enq_ptr, deq_ptr); else n_pass++;
      n_checks++; if (entry_douts[6] !== '0) $display("FAIL rollback_no_enq: got %h want 0", entry_douts[6]); else n_pass++;
   endtask
`endif

   task automatic test_random();
      int cnt;
      logic [NE-1:0] exp_er;
      logic [ND-1:0] exp_dv;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         flush     = ($urandom_range(0, 15) == 0);
         enq_valid = NE'($urandom_range(0, 3));
         deq_ready = ND'($urandom_range(0, 3));
         for (int i = 0; i < NE; i++) enq_data[i] = $urandom();
         for (int p = 0; p < NW; p++) begin
            wr_en[p]   = ($urandom_range(0, 3) == 0);
            wr_addr[p] = PW'($urandom_range(0, N - 1));
            wr_data[p] = $urandom();
         end
         for (int r = 0; r < NR; r++) rd_addr[r] = PW'($urandom_range(0, N - 1));
         #1;
         cnt = m_cnt();
         for (int i = 0; i < NE; i++) exp_er[i] = ((N - cnt) > i);
         for (int i = 0; i < ND; i++) exp_dv[i] = (cnt > i);
         n_checks++; if (count !== CW'(cnt)) $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, cnt); else n_pass++;
         n_checks++; if (enq_ptr !== CW'(m_ep) || deq_ptr !== CW'(m_dp)) $display("FAIL rnd_ptrs c%0d: got %0d/%0d want %0d/%0d", c, enq_ptr, deq_ptr, m_ep, m_dp); else n_pass++;
         n_checks++; if (enq_ready !== exp_er) $display("FAIL rnd_enq_ready c%0d: got %b want %b", c, enq_ready, exp_er); else n_pass++;
         n_checks++; if (deq_valid !== exp_dv) $display("FAIL rnd_deq_valid c%0d: got %b want %b", c, deq_valid, exp_dv); else n_pass++;
         for (int i = 0; i < ND; i++) begin
            n_checks++; if (deq_data[i] !== m_mem[(m_dp + i) % N]) $display("FAIL rnd_deq_data%0d c%0d: got %h want %h", i, c, deq_data[i], m_mem[(m_dp + i) % N]); else n_pass++;
         end
         for (int r = 0; r < NR; r++) begin
            n_checks++; if (rd_data[r] !== m_mem[rd_addr[r]]) $display("FAIL rnd_rd_data%0d c%0d: got %h want %h", r, c, rd_data[r], m_mem[rd_addr[r]]); else n_pass++;
         end
         for (int k = 0; k < N; k++) begin
            n_checks++; if (entry_douts[k] !== m_mem[k]) $display("FAIL rnd_entry%0d c%0d: got %h want %h", k, c, entry_douts[k], m_mem[k]); else n_pass++;
         end
         step();
      end
      idle();
   endtask

   initial begin
      idle();
      m_ep = 0;
      m_dp = 0;
      for (int k = 0; k < N; k++) m_mem[k] = '0;
      test_reset();
      test_basic_enq();
      test_fill();
      test_partial();
      test_wrap();
      test_gap();
      test_flush();
      test_collision();
`ifdef FIFO_RAM_MULTI_ROLLBACK_EN
      test_rollback();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_ram_multi.md
Name: fifo_ram_multi

Overview:
Circular FIFO with N_ENQ in-order enqueue lanes and N_DEQ in-order dequeue lanes per cycle. It also provides random-access read/write ports and a whole-queue flush. It is the superscalar successor to the single-lane FIFO RAM, and backs multi-issue dispatch/commit structures such as the ROB and load/store queues. Counters carry an extra wrap bit so full and empty are always distinguishable, and the occupancy count is exact.

Parameters:
ENTRY_WIDTH, 32, bits per entry
N_ENTRIES, 8, depth; power of 2, >=2
N_ENQ, 2, enqueue lanes; 1..N_ENTRIES
N_DEQ, 2, dequeue lanes; 1..N_ENTRIES
N_READ_PORTS, 2, random-access read ports
N_WRITE_PORTS, 2, random-access write ports
PTR_WIDTH (local), clog2(N_ENTRIES)
CTR_WIDTH (local), PTR_WIDTH+1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  empty the queue next cycle
enq_ready  out  N_ENQ  lane i may accept
enq_valid  in  N_ENQ  lane i has data; must be a contiguous prefix from lane 0
enq_data  in  N_ENQ x ENTRY_WIDTH  lane i data
deq_ready  in  N_DEQ  consumer takes lane i; must be a contiguous prefix
deq_valid  out  N_DEQ  lane i holds a valid entry
deq_data  out  N_DEQ x ENTRY_WIDTH  entry at head+i
rd_addr  in  N_READ_PORTS x PTR_WIDTH  random read index
rd_data  out  N_READ_PORTS x ENTRY_WIDTH  combinational read data
wr_en  in  N_WRITE_PORTS  random write enable
wr_addr  in  N_WRITE_PORTS x PTR_WIDTH  write index
wr_data  in  N_WRITE_PORTS x ENTRY_WIDTH  write data
enq_ptr  out  CTR_WIDTH  tail counter, including wrap bit
deq_ptr  out  CTR_WIDTH  head counter, including wrap bit
count  out  CTR_WIDTH  occupancy, 0..N_ENTRIES
entry_douts  out  N_ENTRIES x ENTRY_WIDTH  all storage

Behaviour:
- Reset (rst=1 at a clk edge): enq_ptr=0, deq_ptr=0, all entries=0. Hence count=0, deq_valid=0, and enq_ready is all ones (when N_ENQ<=N_ENTRIES).
- count = enq_ptr - deq_ptr, computed mod 2^CTR_WIDTH. free = N_ENTRIES - count.
- enq_ready[i] = (free > i).
- deq_valid[i] = (count > i).
- deq_data[i] = entry[(deq_ptr+i) mod N_ENTRIES], combinational. Zero latency from state.
- Enqueue lane i fires iff enq_valid[i] & enq_ready[i] & lane i-1 fired (lane 0 has no predecessor term).
  - n_enq = number of fired lanes.
  - Lane i writes entry[(enq_ptr+i) mod N]. enq_ptr += n_enq.
- Dequeue lane i fires iff deq_ready[i] & deq_valid[i] & lane i-1 fired. deq_ptr += n_deq.
- Non-prefix valid/ready patterns: lanes above the first gap are ignored. No error is raised.
- Enqueue and dequeue in the same cycle are independent. enq_ready depends only on current state: there is no same-cycle dequeue credit and no bypass. Data enqueued at edge t is visible on deq_data from cycle t+1.
- Wrap-around: pointers increment mod 2^CTR_WIDTH. A lane whose slot index exceeds N-1 wraps to slot 0.
- Random writes land at the next edge. Write-collision priority per entry: enqueue lane > higher-index write port > lower-index write port.
- rd_data[i] = entry[rd_addr[i]], combinational, pre-edge value. No write-to-read forwarding.
- Flush: enq_ptr=0 and deq_ptr=0 at the next edge. Enq/deq in that cycle are discarded, and enq_ready/deq_valid still reflect the pre-flush state. Random writes still commit. Entry contents are not cleared.
- rst has priority over flush, flush over rollback, rollback over enqueue.

Optional Feature:
Macro FIFO_RAM_MULTI_ROLLBACK_EN.
- Defined: adds two inputs.
  - rollback_valid (1)
  - rollback_ptr (CTR_WIDTH)
- When rollback_valid=1 and flush=0: enq_ptr <= rollback_ptr, which discards younger entries. Enqueue is suppressed that cycle; dequeue proceeds normally.
- rollback_ptr must lie in the post-dequeue range [deq_ptr+n_deq, enq_ptr], and the caller guarantees this.
- Undefined: the ports are absent and enq_ptr changes only by enqueue, flush or rst.

Test Plan:
- Reset, then enq_valid=2'b11 with data A,B → next cycle count=2, deq_valid=11, deq_data={B,A}, enq_ptr=2.
- Fill N=8 with 2-lane enqueues → after 4 cycles count=8, enq_ready=00, enq_ptr=8 (wrap bit set), deq_valid=11. A further enq_valid=11 does not change count.
- count=7, enq_valid=11 → only lane 0 fires, count=8. With deq_ready=11 in the same cycle, count=6 next cycle; no same-cycle credit is given.
- Pointers at 6: enqueue 4 entries then dequeue 4 → writes land in slots 6,7,0,1, data returns in order, enq_ptr=10, count=0.
- enq_valid=2'b10 (gap) → nothing enqueued, count unchanged.
- flush with count=5 and deq_ready=11 → next cycle count=0, pointers=0, deq_valid=00. With FIFO_RAM_MULTI_ROLLBACK_EN: at enq_ptr=6, deq_ptr=2, rollback_ptr=4 → count=2.
